aes_128_decrypt: RTL and testbench

AES_128_DECRYPT -- requirements
Module: aes_128_decrypt

---
 rtl/aes_dec_pkg.sv | 84 ++++++++
 rtl/aes_key_step.sv | 28 ++
 rtl/aes_128_decrypt.sv | 160 ++++++++++++++++
 tb/tb_aes_128_decrypt.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES-128 inverse-cipher definitions: GF(2^8) arithmetic, forward and
// inverse S-box, round constants, FSM state encoding and key/round counts.
package aes_dec_pkg;

  localparam int NK = 4;
  localparam int NR = 10;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  // rcon_tbl(i) is the constant that produces round key i+1 from round key i.
  function automatic logic [7:0] rcon_tbl(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir=0) or inverse (dir=1).
module aes_key_step
  import aes_dec_pkg::*;
(
  input  logic [32*NK-1:0] key,
  input  logic [7:0]       rcon,
  input  logic             dir,
  output logic [32*NK-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3, tw, sw;

  // The inverse step recovers old w3 first, so both directions share one SubWord.
  always_comb begin
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    tw = dir ? (w3 ^ w2) : w3;
    sw = {sbox(tw[23:16]), sbox(tw[15:8]), sbox(tw[7:0]), sbox(tw[31:24])} ^ {rcon, 24'h000000};
    if (dir) begin
      next_key = {w0 ^ sw, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end else begin
      next_key = {w0 ^ sw, w1 ^ w0 ^ sw, w2 ^ w1 ^ w0 ^ sw, w3 ^ w2 ^ w1 ^ w0 ^ sw};
    end
  end

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 decryptor: one key-schedule step or inverse round per cycle.
// Optional round-key cache enabled by defining AES_DEC_KEY_CACHE_EN: a start
// with the last expanded key skips KEYEXP and reuses the stored round key 10.
module aes_128_decrypt
  import aes_dec_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int KEY_SIZE     = 128,
  parameter int ROUNDS       = NR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BLOCK_LENGTH-1:0] in_state,
  input  logic [KEY_SIZE-1:0]     in_key,
  output logic [BLOCK_LENGTH-1:0] out_state,
  output logic                    busy,
  output logic                    done
);

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t                  fsm, fsm_nxt;
  logic [3:0]              cnt;
  logic [3:0]              rc_idx;
  logic [BLOCK_LENGTH-1:0] state_q;
  logic [KEY_SIZE-1:0]     key_q, key_nxt, load_key;
  logic [127:0]            ark, imc;
  logic [7:0]              a0, a1, a2, a3;
  logic                    hit;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [KEY_SIZE-1:0] cache_key, cache_rk;
  logic                cache_vld;

  assign hit      = cache_vld && (cache_key == in_key);
  assign load_key = hit ? cache_rk : in_key;

  // Remember the key on a miss; commit its round key 10 once KEYEXP finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_key <= '0;
      cache_rk  <= '0;
      cache_vld <= 1'b0;
    end else if (fsm == IDLE && start && !hit) begin
      cache_key <= in_key;
      cache_vld <= 1'b0;
    end else if (fsm == KEYEXP && cnt == LAST) begin
      cache_rk  <= key_nxt;
      cache_vld <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign load_key = in_key;
`endif

  assign busy = (fsm != IDLE);

  // KEYEXP walks rk0->rk10 with rcon(cnt); INIT/ROUND walk back, rk r -> rk r-1 uses rcon(r-1).
  always_comb begin
    rc_idx = cnt;
    if (fsm == INIT) rc_idx = LAST;
    else if (fsm == ROUND) rc_idx = cnt - 4'd1;
  end

  aes_key_step u_key_step (
    .key      (key_q),
    .rcon     (rcon_tbl(rc_idx)),
    .dir      (fsm != KEYEXP),
    .next_key (key_nxt)
  );

  // Inverse round: InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns.
  always_comb begin
    ark = '0;
    imc = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127 - 8*(4*c + r) -: 8] =
          inv_sbox(state_q[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]) ^ key_q[127 - 8*(4*c + r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127 - 32*c -: 8];
      a1 = ark[119 - 32*c -: 8];
      a2 = ark[111 - 32*c -: 8];
      a3 = ark[103 - 32*c -: 8];
      imc[127 - 32*c -: 32] = {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                               mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                               mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
                               mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (start) fsm_nxt = hit ? INIT : KEYEXP;
      KEYEXP:  if (cnt == LAST) fsm_nxt = INIT;
      INIT:    fsm_nxt = ROUND;
      ROUND:   if (cnt == 4'd0) fsm_nxt = DONE;
      DONE:    fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Datapath: capture, key schedule, rounds and the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      key_q     <= '0;
      cnt       <= '0;
      out_state <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            state_q <= in_state;
            key_q   <= load_key;
            cnt     <= '0;
          end
        end
        KEYEXP: begin
          key_q <= key_nxt;
          cnt   <= cnt + 4'd1;
        end
        INIT: begin
          state_q <= state_q ^ key_q;
          key_q   <= key_nxt;
          cnt     <= LAST;
        end
        ROUND: begin
          state_q <= (cnt == 4'd0) ? ark : imc;
          key_q   <= key_nxt;
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        DONE: begin
          out_state <= state_q;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Self-checking bench for aes_128_decrypt: FIPS-197 vectors, ignored start,
// mid-operation reset, back-to-back operations and random encrypt/decrypt
// round trips against an in-bench AES-128 encryption model.
module tb_aes_128_decrypt;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic [127:0] out_state;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0]   sb_m [256];
  bit           cm_vld = 1'b0;
  logic [127:0] cm_key = '0;

  aes_128_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_state  (in_state),
    .in_key    (in_key),
    .out_state (out_state),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int p, x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x >= 256) x = x ^ 32'h11b;
    end
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = s[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
      sb_m[x] = s;
    end
  endtask

  function automatic logic [127:0] m_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]], sb_m[tmp[31:24]]} ^ {rc, 24'h000000};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[j + 4*c] = t[j + 4*((c + j) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // Expected start-to-done latency, tracking what the key cache would hold.
  task automatic model_start(input logic [127:0] key, output int lat);
    lat = 22;
`ifdef AES_DEC_KEY_CACHE_EN
    if (cm_vld && cm_key == key) lat = 12;
`endif
    cm_vld = 1'b1;
    cm_key = key;
  endtask

  // Issue one start and wait (bounded) for done; lat=-1 on timeout.
  task automatic run_op(input logic [127:0] ct, input logic [127:0] key,
                        output logic [127:0] got, output int lat,
                        output logic busy_seen, output logic [127:0] held);
    @(negedge clk);
    start    = 1'b1;
    in_state = ct;
    in_key   = key;
    @(posedge clk);
    #1;
    start     = 1'b0;
    in_state  = ~ct;
    in_key    = ~key;
    busy_seen = busy;
    held      = out_state;
    lat       = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    got = out_state;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (out_state !== 128'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", out_state); end
    @(negedge clk);
    rst = 1'b0;
    cm_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_vector1();
    logic [127:0] got, held;
    int lat, elat;
    logic bs;
    model_start(K1, elat);
    run_op(C1, K1, got, lat, bs, held);
    n_cmp++; if (got !== P1) begin n_bad++; $display("FAIL v1_plain: got %h want %h", got, P1); end
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL v1_latency: got %0d want %0d", lat, elat); end
    n_cmp++; if (bs !== 1'b1) begin n_bad++; $display("FAIL v1_busy: got %b want 1", bs); end
    @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL v1_done_pulse: got %b want 0", done); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_state !== P1) begin n_bad++; $display("FAIL v1_hold: got %h want %h", out_state, P1); end
  endtask

  task automatic test_vector2();
    logic [127:0] got, held;
    int lat, elat;
    logic bs;
    model_start(K2, elat);
    run_op(C2, K2, got, lat, bs, held);
    n_cmp++; if (got !== P2) begin n_bad++; $display("FAIL v2_plain: got %h want %h", got, P2); end
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL v2_latency: got %0d want %0d", lat, elat); end
    n_cmp++; if (held !== P1) begin n_bad++; $display("FAIL v2_prev_hold: got %h want %h", held, P1); end
  endtask

  task automatic test_ignore_start();
    int lat, elat;
    model_start(K1, elat);
    @(negedge clk);
    start = 1'b1; in_state = C1; in_key = K1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      start = (i == 15);
      if (i == 15) begin in_state = C2; in_key = K2; end
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    n_cmp++; if (out_state !== P1) begin n_bad++; $display("FAIL ignore_plain: got %h want %h", out_state, P1); end
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, elat); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_restart: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got, held;
    int lat, elat;
    logic bs;
    model_start(K2, elat);
    @(negedge clk);
    start = 1'b1; in_state = C2; in_key = K2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
    n_cmp++; if (out_state !== 128'h0) begin n_bad++; $display("FAIL midrst_out: got %h want 0", out_state); end
    cm_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    n_cmp++; if (out_state !== 128'h0) begin n_bad++; $display("FAIL midrst_no_partial: got %h want 0", out_state); end
    model_start(K1, elat);
    run_op(C1, K1, got, lat, bs, held);
    n_cmp++; if (got !== P1) begin n_bad++; $display("FAIL midrst_v1_plain: got %h want %h", got, P1); end
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL midrst_v1_latency: got %0d want %0d", lat, elat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got, held;
    int lat, elat;
    logic bs;
    model_start(K2, elat);
    run_op(C2, K2, got, lat, bs, held);
    n_cmp++; if (got !== P2) begin n_bad++; $display("FAIL b2b_a_plain: got %h want %h", got, P2); end
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL b2b_a_latency: got %0d want %0d", lat, elat); end
    model_start(K2, elat);
    run_op(C2, K2, got, lat, bs, held);
    n_cmp++; if (got !== P2) begin n_bad++; $display("FAIL b2b_b_plain: got %h want %h", got, P2); end
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL b2b_b_latency: got %0d want %0d", lat, elat); end
    model_start(K1, elat);
    run_op(C1, K1, got, lat, bs, held);
    n_cmp++; if (held !== P2) begin n_bad++; $display("FAIL b2b_c_hold: got %h want %h", held, P2); end
    n_cmp++; if (got !== P1) begin n_bad++; $display("FAIL b2b_c_plain: got %h want %h", got, P1); end
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL b2b_c_latency: got %0d want %0d", lat, elat); end
  endtask

  task automatic test_round_trip();
    logic [127:0] pt, key, ct, got, held;
    logic [127:0] prev_key;
    int lat, elat;
    logic bs;
    prev_key = K1;
    for (int n = 0; n < 1000; n++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = (n % 4 == 3) ? prev_key : {$urandom, $urandom, $urandom, $urandom};
      prev_key = key;
      ct = m_enc(pt, key);
      model_start(key, elat);
      run_op(ct, key, got, lat, bs, held);
      n_cmp++; if (got !== pt) begin n_bad++; $display("FAIL rt_plain[%0d]: got %h want %h", n, got, pt); end
      n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL rt_latency[%0d]: got %0d want %0d", n, lat, elat); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vector1();
    test_vector2();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
